// File: rtl/power_pkg.sv
// Shared types and defaults for the power-domain sequencer.
package power_pkg;

    localparam int unsigned PD_NUM_CORES_DEFAULT   = 4;
    localparam int unsigned PD_STEP_CYCLES_DEFAULT = 2;
    localparam int unsigned PD_ACK_TIMEOUT_DEFAULT = 256;
    localparam int unsigned PD_STEP_CNT_W          = 8;
    localparam int unsigned PD_TMO_CNT_W           = 16;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_CLK_OFF,
        SEQ_ISO_ON,
        SEQ_SAVE,
        SEQ_PWR_OFF,
        SEQ_PWR_ON,
        SEQ_RESTORE,
        SEQ_ISO_OFF,
        SEQ_CLK_ON
    } pd_seq_state_t;

endpackage

// File: rtl/power_seq_rr_arbiter.sv
// Round-robin pick of one requesting core, searching upward from ptr_i with wrap.
module power_seq_rr_arbiter #(
    parameter int unsigned NUM_CORES = 4
) (
    input  logic [NUM_CORES-1:0]         req_i,
    input  logic [$clog2(NUM_CORES)-1:0] ptr_i,
    output logic [NUM_CORES-1:0]         gnt_o,
    output logic [$clog2(NUM_CORES)-1:0] idx_o
);

    localparam int unsigned IW = $clog2(NUM_CORES);

    // Scan farthest-first so the candidate nearest the pointer is written last.
    always_comb begin
        int unsigned c;
        c     = 0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
            c = (32'(ptr_i) + 32'(k)) % NUM_CORES;
            if (req_i[c]) begin
                gnt_o = NUM_CORES'(1) << c;
                idx_o = IW'(c);
            end
        end
    end

endmodule

// File: rtl/power_domain_sequencer.sv
// Serialised per-core power-down/power-up sequencer with round-robin grant.
// Optional retention save/restore steps: define POWER_SEQ_RETENTION_EN.
module power_domain_sequencer
    import power_pkg::*;
#(
    parameter int unsigned NUM_CORES   = PD_NUM_CORES_DEFAULT,
    parameter int unsigned STEP_CYCLES = PD_STEP_CYCLES_DEFAULT,
    parameter int unsigned ACK_TIMEOUT = PD_ACK_TIMEOUT_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CORES-1:0]         sleep_req_i,
    input  logic [NUM_CORES-1:0]         wake_req_i,
    input  logic [NUM_CORES-1:0]         pwr_ack_i,
    input  logic                         err_clr_i,
    output logic [NUM_CORES-1:0]         clk_en_o,
    output logic [NUM_CORES-1:0]         iso_en_o,
    output logic [NUM_CORES-1:0]         ret_save_o,
    output logic [NUM_CORES-1:0]         ret_restore_o,
    output logic [NUM_CORES-1:0]         pwr_en_o,
    output logic [NUM_CORES-1:0]         domain_on_o,
    output logic                         busy_o,
    output logic [$clog2(NUM_CORES)-1:0] seq_core_o,
    output logic                         done_o,
    output logic [NUM_CORES-1:0]         err_timeout_o
);

    localparam int unsigned IW = $clog2(NUM_CORES);

    pd_seq_state_t            state_q;
    logic [IW-1:0]            rr_ptr_q;
    logic [PD_STEP_CNT_W-1:0] step_cnt_q;
    logic [PD_TMO_CNT_W-1:0]  tmo_cnt_q;

    logic [NUM_CORES-1:0] wake_elig_c, sleep_elig_c, wake_gnt_c, sleep_gnt_c;
    logic [IW-1:0]        wake_idx_c, sleep_idx_c, gnt_idx_c, ptr_next_c;
    logic                 wake_any_c, sleep_any_c, step_last_c, tmo_last_c, ack_c;

    assign wake_elig_c  = wake_req_i & ~domain_on_o;
    assign sleep_elig_c = sleep_req_i & domain_on_o & ~wake_req_i;

    power_seq_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_wake_arb (
        .req_i (wake_elig_c),
        .ptr_i (rr_ptr_q),
        .gnt_o (wake_gnt_c),
        .idx_o (wake_idx_c)
    );

    power_seq_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_sleep_arb (
        .req_i (sleep_elig_c),
        .ptr_i (rr_ptr_q),
        .gnt_o (sleep_gnt_c),
        .idx_o (sleep_idx_c)
    );

    assign wake_any_c  = |wake_gnt_c;
    assign sleep_any_c = |sleep_gnt_c;
    assign gnt_idx_c   = wake_any_c ? wake_idx_c : sleep_idx_c;
    assign ptr_next_c  = (32'(gnt_idx_c) == NUM_CORES - 1) ? '0 : gnt_idx_c + IW'(1);
    assign step_last_c = (step_cnt_q == PD_STEP_CNT_W'(STEP_CYCLES - 1));
    assign tmo_last_c  = (tmo_cnt_q == PD_TMO_CNT_W'(ACK_TIMEOUT - 1));
    assign ack_c       = pwr_ack_i[seq_core_o];

`ifndef POWER_SEQ_RETENTION_EN
    assign ret_save_o    = '0;
    assign ret_restore_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= SEQ_IDLE;
            rr_ptr_q      <= '0;
            step_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            clk_en_o      <= '1;
            pwr_en_o      <= '1;
            domain_on_o   <= '1;
            iso_en_o      <= '0;
`ifdef POWER_SEQ_RETENTION_EN
            ret_save_o    <= '0;
            ret_restore_o <= '0;
`endif
            err_timeout_o <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            seq_core_o    <= '0;
        end else begin
            done_o     <= 1'b0;
            step_cnt_q <= step_cnt_q + PD_STEP_CNT_W'(1);
            tmo_cnt_q  <= tmo_cnt_q + PD_TMO_CNT_W'(1);
            // A timeout flag set below overrides a same-cycle clear.
            if (err_clr_i) err_timeout_o <= '0;
            case (state_q)
                SEQ_IDLE: begin
                    step_cnt_q <= '0;
                    tmo_cnt_q  <= '0;
                    if (wake_any_c || sleep_any_c) begin
                        busy_o     <= 1'b1;
                        seq_core_o <= gnt_idx_c;
                        rr_ptr_q   <= ptr_next_c;
                        if (wake_any_c) begin
                            state_q              <= SEQ_PWR_ON;
                            pwr_en_o[wake_idx_c] <= 1'b1;
                        end else begin
                            state_q               <= SEQ_CLK_OFF;
                            clk_en_o[sleep_idx_c] <= 1'b0;
                        end
                    end
                end
                SEQ_CLK_OFF: if (step_last_c) begin
                    state_q              <= SEQ_ISO_ON;
                    iso_en_o[seq_core_o] <= 1'b1;
                    step_cnt_q           <= '0;
                    tmo_cnt_q            <= '0;
                end
                SEQ_ISO_ON: if (step_last_c) begin
`ifdef POWER_SEQ_RETENTION_EN
                    state_q                <= SEQ_SAVE;
                    ret_save_o[seq_core_o] <= 1'b1;
`else
                    state_q              <= SEQ_PWR_OFF;
                    pwr_en_o[seq_core_o] <= 1'b0;
`endif
                    step_cnt_q <= '0;
                    tmo_cnt_q  <= '0;
                end
`ifdef POWER_SEQ_RETENTION_EN
                SEQ_SAVE: if (step_last_c) begin
                    state_q                <= SEQ_PWR_OFF;
                    ret_save_o[seq_core_o] <= 1'b0;
                    pwr_en_o[seq_core_o]   <= 1'b0;
                    step_cnt_q             <= '0;
                    tmo_cnt_q              <= '0;
                end
                SEQ_RESTORE: if (step_last_c) begin
                    state_q                   <= SEQ_ISO_OFF;
                    ret_restore_o[seq_core_o] <= 1'b0;
                    iso_en_o[seq_core_o]      <= 1'b0;
                    step_cnt_q                <= '0;
                    tmo_cnt_q                 <= '0;
                end
`endif
                SEQ_PWR_OFF: if (!ack_c || tmo_last_c) begin
                    if (ack_c) err_timeout_o[seq_core_o] <= 1'b1;
                    state_q                 <= SEQ_IDLE;
                    domain_on_o[seq_core_o] <= 1'b0;
                    busy_o                  <= 1'b0;
                    done_o                  <= 1'b1;
                    step_cnt_q              <= '0;
                    tmo_cnt_q               <= '0;
                end
                SEQ_PWR_ON: if (ack_c || tmo_last_c) begin
                    if (!ack_c) err_timeout_o[seq_core_o] <= 1'b1;
`ifdef POWER_SEQ_RETENTION_EN
                    state_q                   <= SEQ_RESTORE;
                    ret_restore_o[seq_core_o] <= 1'b1;
`else
                    state_q              <= SEQ_ISO_OFF;
                    iso_en_o[seq_core_o] <= 1'b0;
`endif
                    step_cnt_q <= '0;
                    tmo_cnt_q  <= '0;
                end
                SEQ_ISO_OFF: if (step_last_c) begin
                    state_q              <= SEQ_CLK_ON;
                    clk_en_o[seq_core_o] <= 1'b1;
                    step_cnt_q           <= '0;
                    tmo_cnt_q            <= '0;
                end
                SEQ_CLK_ON: if (step_last_c) begin
                    state_q                 <= SEQ_IDLE;
                    domain_on_o[seq_core_o] <= 1'b1;
                    busy_o                  <= 1'b0;
                    done_o                  <= 1'b1;
                    step_cnt_q              <= '0;
                    tmo_cnt_q               <= '0;
                end
                default: begin
                    state_q    <= SEQ_IDLE;
                    busy_o     <= 1'b0;
                    step_cnt_q <= '0;
                    tmo_cnt_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Directed bench for power_domain_sequencer: cycle-exact step checks plus a completion scoreboard.
module tb_power_domain_sequencer;

    localparam int unsigned NC  = 4;
    localparam int unsigned S   = 2;
    localparam int unsigned TMO = 8;
`ifdef POWER_SEQ_RETENTION_EN
    localparam int unsigned RET = 1;
`else
    localparam int unsigned RET = 0;
`endif

    typedef struct packed {
        logic [1:0]    core;
        logic [NC-1:0] dom;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [NC-1:0] sleep_req_i = '0;
    logic [NC-1:0] wake_req_i = '0;
    logic [NC-1:0] pwr_ack_i;
    logic          err_clr_i = 1'b0;
    logic [NC-1:0] clk_en_o, iso_en_o, ret_save_o, ret_restore_o, pwr_en_o, domain_on_o, err_timeout_o;
    logic          busy_o, done_o;
    logic [1:0]    seq_core_o;

    logic          ack_auto = 1'b0;
    logic [NC-1:0] ack_man = '1;
    logic [NC-1:0] ack_follow = '1;
    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;

    power_domain_sequencer #(.NUM_CORES(NC), .STEP_CYCLES(S), .ACK_TIMEOUT(TMO)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sleep_req_i   (sleep_req_i),
        .wake_req_i    (wake_req_i),
        .pwr_ack_i     (pwr_ack_i),
        .err_clr_i     (err_clr_i),
        .clk_en_o      (clk_en_o),
        .iso_en_o      (iso_en_o),
        .ret_save_o    (ret_save_o),
        .ret_restore_o (ret_restore_o),
        .pwr_en_o      (pwr_en_o),
        .domain_on_o   (domain_on_o),
        .busy_o        (busy_o),
        .seq_core_o    (seq_core_o),
        .done_o        (done_o),
        .err_timeout_o (err_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Switch model: rail follows its enable one cycle later.
    always @(posedge clk_i) ack_follow <= pwr_en_o;
    assign pwr_ack_i = ack_auto ? ack_follow : ack_man;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [1:0] core, input logic [NC-1:0] dom);
        exp_t e;
        e.core = core;
        e.dom  = dom;
        sb.push_back(e);
    endtask

    task automatic sb_check_done(input string tag);
        exp_t e;
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_core"}, 32'(seq_core_o), 32'(e.core));
            chk({tag, "_dom"}, 32'(domain_on_o), 32'(e.dom));
            chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        end
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (!done_o && k < 200);
        sb_check_done(tag);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_clk_en"}, 32'(clk_en_o), 32'b1111);
        chk({tag, "_pwr_en"}, 32'(pwr_en_o), 32'b1111);
        chk({tag, "_dom"}, 32'(domain_on_o), 32'b1111);
        chk({tag, "_iso"}, 32'(iso_en_o), 32'd0);
        chk({tag, "_save"}, 32'(ret_save_o), 32'd0);
        chk({tag, "_restore"}, 32'(ret_restore_o), 32'd0);
        chk({tag, "_err"}, 32'(err_timeout_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_core"}, 32'(seq_core_o), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b1;
        tick(1);
        chk_reset_state(tag);
        rst_i = 1'b0;
    endtask

    initial begin
        tick(2);
        chk_reset_state("rst0");
        rst_i = 1'b0;
        tick(1);

        // Single sleep of core 2, ack drops 3 cycles after power-off.
        sb_push(2'd2, 4'b1011);
        sleep_req_i = 4'b0100;
        tick(1);
        sleep_req_i = '0;
        chk("t1_clk_off", 32'(clk_en_o), 32'b1011);
        chk("t1_busy", 32'(busy_o), 32'd1);
        chk("t1_core", 32'(seq_core_o), 32'd2);
        chk("t1_iso_pre", 32'(iso_en_o), 32'd0);
        tick(S);
        chk("t1_iso_on", 32'(iso_en_o), 32'b0100);
`ifdef POWER_SEQ_RETENTION_EN
        tick(S);
        chk("t1_save", 32'(ret_save_o), 32'b0100);
        chk("t1_pwr_pre", 32'(pwr_en_o), 32'b1111);
`endif
        tick(S);
        chk("t1_pwr_off", 32'(pwr_en_o), 32'b1011);
        chk("t1_save_off", 32'(ret_save_o), 32'd0);
        tick(3);
        chk("t1_no_done", 32'(done_o), 32'd0);
        ack_man = 4'b1011;
        tick(1);
        sb_check_done("t1");
        tick(1);
        chk("t1_pulse", 32'(done_o), 32'd0);

        // Wake core 2 with ack the first cycle of power-on.
        sb_push(2'd2, 4'b1111);
        wake_req_i = 4'b0100;
        tick(1);
        wake_req_i = '0;
        chk("t2_pwr_on", 32'(pwr_en_o), 32'b1111);
        chk("t2_core", 32'(seq_core_o), 32'd2);
        ack_man = 4'b1111;
        tick(1);
`ifdef POWER_SEQ_RETENTION_EN
        chk("t2_restore", 32'(ret_restore_o), 32'b0100);
        chk("t2_iso_held", 32'(iso_en_o), 32'b0100);
        tick(S);
`endif
        chk("t2_iso_off", 32'(iso_en_o), 32'd0);
        chk("t2_restore_off", 32'(ret_restore_o), 32'd0);
        chk("t2_clk_pre", 32'(clk_en_o), 32'b1011);
        tick(S);
        chk("t2_clk_on", 32'(clk_en_o), 32'b1111);
        tick(S - 1);
        chk("t2_no_done", 32'(done_o), 32'd0);
        tick(1);
        sb_check_done("t2");

        // Three held sleeps from a fresh pointer: order 0, 1, 3.
        do_reset("rst1");
        ack_auto = 1'b1;
        sb_push(2'd0, 4'b1110);
        sb_push(2'd1, 4'b1100);
        sb_push(2'd3, 4'b0100);
        sleep_req_i = 4'b1011;
        wait_done("t3a");
        wait_done("t3b");
        wait_done("t3c");
        sleep_req_i = '0;

        // Wake on off core 3 beats sleep on core 2 in the same cycle.
        sb_push(2'd3, 4'b1100);
        sb_push(2'd2, 4'b1000);
        sleep_req_i = 4'b0100;
        wake_req_i  = 4'b1000;
        tick(1);
        chk("t4_wake_first", 32'(seq_core_o), 32'd3);
        wait_done("t4a");
        wait_done("t4b");
        sleep_req_i = '0;
        wake_req_i  = '0;

        // Ack stuck high: timeout after TMO cycles in power-off, then clear.
        do_reset("rst2");
        ack_auto = 1'b0;
        ack_man  = 4'b1111;
        sb_push(2'd0, 4'b1110);
        sleep_req_i = 4'b0001;
        tick(1);
        sleep_req_i = '0;
        tick((2 + RET) * S);
        chk("t5_pwr_off", 32'(pwr_en_o), 32'b1110);
        tick(TMO - 1);
        chk("t5_no_done", 32'(done_o), 32'd0);
        chk("t5_no_err", 32'(err_timeout_o), 32'd0);
        tick(1);
        sb_check_done("t5");
        chk("t5_err", 32'(err_timeout_o), 32'b0001);
        tick(1);
        chk("t5_sticky", 32'(err_timeout_o), 32'b0001);
        err_clr_i = 1'b1;
        tick(1);
        err_clr_i = 1'b0;
        chk("t5_clr", 32'(err_timeout_o), 32'd0);

        // Ack stuck low on wake, clear asserted in the timeout cycle: flag still set.
        ack_man = 4'b1110;
        sb_push(2'd0, 4'b1111);
        wake_req_i = 4'b0001;
        tick(1);
        wake_req_i = '0;
        chk("t5w_pwr_on", 32'(pwr_en_o), 32'b1111);
        tick(TMO - 1);
        chk("t5w_no_err", 32'(err_timeout_o), 32'd0);
        err_clr_i = 1'b1;
        tick(1);
        err_clr_i = 1'b0;
        chk("t5w_set_wins", 32'(err_timeout_o), 32'b0001);
        wait_done("t5w");

        // Reset in the middle of ISO_ON.
        ack_man = 4'b1111;
        sleep_req_i = 4'b0010;
        tick(1);
        chk("t6_clk_off", 32'(clk_en_o), 32'b1101);
        tick(S);
        chk("t6_iso_on", 32'(iso_en_o), 32'b0010);
        rst_i = 1'b1;
        tick(1);
        chk_reset_state("t6");
        rst_i = 1'b0;
        sleep_req_i = '0;
        tick(1);
        chk("t6_idle", 32'(busy_o), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
